// File: rtl/serial_word_assembler_pkg.sv
// Shared definitions for the serial word assembler: FSM encoding and default delimiters.
package serial_word_assembler_pkg;

  typedef enum logic {
    StCollect = 1'b0,
    StHold    = 1'b1
  } state_e;

  localparam logic [7:0] DelimSpace   = 8'h20;
  localparam logic [7:0] DelimNewline = 8'h0A;

endpackage

// File: rtl/serial_word_assembler_word_buffer_ram.sv
// Word byte buffer: one synchronous write port, one asynchronous read port, no reset.
module word_buffer_ram #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] r_mem [DEPTH];

  // Store one byte per accepted non-delimiter.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/serial_word_assembler.sv
// Pulls bytes from a serial receiver, splits them into delimiter-separated words and
// holds each completed word until the consumer acknowledges it.
module serial_word_assembler
  import serial_word_assembler_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter logic [7:0]  DELIM_A = DelimSpace,
  parameter logic [7:0]  DELIM_B = DelimNewline
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_no_data,
  output logic       rx_read,
  output logic       word_valid,
  output logic [4:0] word_len,
  output logic       word_overflow,
  input  logic [3:0] word_rd_addr,
  output logic [7:0] word_rd_data,
  input  logic       word_ack,
  output logic [7:0] word_count
);

  localparam logic [4:0] LenMax = 5'(MAX_LEN);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [4:0] r_len;
  logic [4:0] w_len_nxt;
  logic       r_ovf;
  logic       w_ovf_nxt;
  logic [7:0] r_count;
  logic [7:0] w_count_nxt;
  logic       w_we;
  logic       w_accept;
  logic       w_is_delim;

  assign w_accept   = (r_state == StCollect) && !rx_no_data;
  assign w_is_delim = (rx_data == DELIM_A) || (rx_data == DELIM_B);

  // State, length, overflow flag and word counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StCollect;
      r_len   <= 5'd0;
      r_ovf   <= 1'b0;
      r_count <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_ovf   <= w_ovf_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state logic: collect bytes until a delimiter or a full buffer, then hold for ack.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_ovf_nxt   = r_ovf;
    w_count_nxt = r_count;
    w_we        = 1'b0;
    unique case (r_state)
      StCollect: begin
        if (w_accept) begin
          if (w_is_delim) begin
            // Delimiters on an empty buffer are dropped so delimiter runs make no empty words.
            if (r_len != 5'd0) begin
              w_state_nxt = StHold;
              w_ovf_nxt   = 1'b0;
              w_count_nxt = r_count + 8'd1;
            end
          end else begin
            w_we      = 1'b1;
            w_len_nxt = r_len + 5'd1;
            if ((r_len + 5'd1) == LenMax) begin
              w_state_nxt = StHold;
              w_ovf_nxt   = 1'b1;
              w_count_nxt = r_count + 8'd1;
            end
          end
        end
      end
      StHold: begin
        if (word_ack) begin
          w_state_nxt = StCollect;
          w_len_nxt   = 5'd0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = StCollect;
    endcase
  end

  word_buffer_ram #(
    .DEPTH(MAX_LEN)
  ) u_word_buffer_ram (
    .clk    (clk),
    .wr_en  (w_we),
    .wr_addr(r_len[3:0]),
    .wr_data(rx_data),
    .rd_addr(word_rd_addr),
    .rd_data(word_rd_data)
  );

  assign rx_read       = (r_state == StCollect);
  assign word_valid    = (r_state == StHold);
  assign word_len      = r_len;
  assign word_overflow = r_ovf;
  assign word_count    = r_count;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Scoreboard bench for serial_word_assembler: stimulus queues expected words, a monitor
// checks each held word, enforces hold time and acknowledges it.
module tb_serial_word_assembler;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_no_data;
  logic       rx_read;
  logic       word_valid;
  logic [4:0] word_len;
  logic       word_overflow;
  logic [3:0] word_rd_addr;
  logic [7:0] word_rd_data;
  logic       word_ack;
  logic [7:0] word_count;

  typedef struct {
    logic [15:0][7:0] data;
    int               len;
    logic             ovf;
    logic [7:0]       cnt;
    int               hold;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_cnt;
  int         n_checks;
  int         n_errors;

  serial_word_assembler dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_no_data   (rx_no_data),
    .rx_read      (rx_read),
    .word_valid   (word_valid),
    .word_len     (word_len),
    .word_overflow(word_overflow),
    .word_rd_addr (word_rd_addr),
    .word_rd_data (word_rd_data),
    .word_ack     (word_ack),
    .word_count   (word_count)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Queue the expected response for a word about to be streamed.
  task automatic expect_word(input string w, input logic ovf, input int hold);
    exp_t e;
    e.data = '0;
    for (int i = 0; i < w.len(); i++) e.data[i] = w[i];
    e.len   = w.len();
    e.ovf   = ovf;
    exp_cnt = exp_cnt + 8'd1;
    e.cnt   = exp_cnt;
    e.hold  = hold;
    sb.push_back(e);
  endtask

  // Present one byte and wait (bounded) until an edge accepts it.
  task automatic send_byte(input logic [7:0] b, input bit completes);
    bit done;
    done       = 1'b0;
    rx_data    = b;
    rx_no_data = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (rx_read === 1'b1) begin
        if (completes) check("valid_before_complete", word_valid, 1'b0);
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    rx_no_data = 1'b1;
    if (!done) check("rx_read_timeout", 32'd0, 32'd1);
    else if (completes) check("valid_latency", word_valid, 1'b1);
  endtask

  task automatic send_str(input string s, input bit last_completes);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], last_completes && (i == s.len() - 1));
  endtask

  // Monitor: compare each held word against the scoreboard, then ack it.
  initial begin
    exp_t e;
    word_ack     = 1'b0;
    word_rd_addr = 4'd0;
    forever begin
      @(negedge clk);
      if (word_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("word_len", 32'(word_len), 32'(e.len));
          check("word_overflow", 32'(word_overflow), 32'(e.ovf));
          check("word_count", 32'(word_count), 32'(e.cnt));
          for (int i = 0; i < e.len; i++) begin
            word_rd_addr = 4'(i);
            #1;
            check($sformatf("word_byte%0d", i), 32'(word_rd_data), 32'(e.data[i]));
          end
          for (int c = 0; c < e.hold; c++) begin
            @(negedge clk);
            check("hold_rx_read", 32'(rx_read), 32'd0);
            check("hold_len_stable", 32'(word_len), 32'(e.len));
          end
        end
        word_ack = 1'b1;
        @(posedge clk);
        #1;
        word_ack = 1'b0;
        check("ack_releases", 32'(word_valid), 32'd0);
      end
    end
  end

  // Stimulus.
  initial begin
    n_checks   = 0;
    n_errors   = 0;
    exp_cnt    = 8'd0;
    rst        = 1'b1;
    rx_data    = 8'h00;
    rx_no_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_ovf", 32'(word_overflow), 32'd0);
    check("rst_len", 32'(word_len), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_rx_read", 32'(rx_read), 32'd1);

    // Basic word, then a long hold with the next word already pending.
    expect_word("hello", 1'b0, 50);
    expect_word("world", 1'b0, 2);
    send_str("hello ", 1'b1);
    send_str("world\n", 1'b1);

    // Leading and repeated delimiters make no empty words.
    expect_word("a", 1'b0, 2);
    send_str("  \n a ", 1'b1);

    // Overflow at 16 bytes; the tail forms the next word.
    expect_word("AAAAAAAAAAAAAAAA", 1'b1, 2);
    expect_word("AA", 1'b0, 2);
    send_str("AAAAAAAAAAAAAAAA", 1'b1);
    send_str("AA ", 1'b1);

    // Reset in the middle of a word discards it and clears the counter.
    send_str("xyz", 1'b0);
    rst = 1'b1;
    #1;
    check("midword_rst_count", 32'(word_count), 32'd0);
    check("midword_rst_len", 32'(word_len), 32'd0);
    check("midword_rst_valid", 32'(word_valid), 32'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    exp_cnt = 8'd0;
    expect_word("ok", 1'b0, 2);
    send_str("ok ", 1'b1);

    // 255 more words take the counter to 256, which wraps to 0.
    for (int w = 0; w < 255; w++) begin
      expect_word("x", 1'b0, 0);
      send_str("x ", 1'b1);
    end

    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clk);
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("count_wrapped", 32'(word_count), 32'd0);
    check("idle_valid", 32'(word_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
